// File: rtl/rf_dbg_pkg.sv
// Shared constants and state encoding for the register-file debug reader.
package rf_dbg_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HALT_WAIT = 3'd1;
    localparam logic [2:0] S_READ      = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    typedef enum logic [2:0] {
        stIdle     = S_IDLE,
        stHaltWait = S_HALT_WAIT,
        stRead     = S_READ,
        stSend     = S_SEND,
        stDone     = S_DONE
    } dumpState_t;

endpackage

// File: rtl/rf_dump_if.sv
// Valid/ready beat stream carrying (register index, register value) pairs.
interface rf_dump_if
    import rf_dbg_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) ();

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, output out_addr, output out_data, input out_ready);
    modport slave  (input out_valid, input out_addr, input out_data, output out_ready);

endinterface

// File: rtl/rf_dump.sv
// Register-file debug reader: halts the CPU, walks the spare async read port
// one register at a time and streams (index, value) beats to a debug sink.
module rf_dump
    import rf_dbg_pkg::*;
#(
    parameter int NUM_REGS  = RF_NUM_REGS,
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int DATA_W    = RF_DATA_W,
    parameter int FIRST_REG = 1,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              halt_req,
    input  logic              halt_ack,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    rf_dump_if.master         beatOut
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    dumpState_t        state;
    logic [ADDR_W-1:0] idx;
    logic              outValid;
    logic [ADDR_W-1:0] outAddr;
    logic [DATA_W-1:0] outData;
    logic              isLast;

    assign isLast            = (idx == LAST_IDX);
    assign rf_addr           = idx;
    assign beatOut.out_valid = outValid;
    assign beatOut.out_addr  = outAddr;
    assign beatOut.out_data  = outData;

    // NOTE: state, index and every output are registers written with <= in
    // this single clocked block, so they all update on the same edge and the
    // reset branch clears them together in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= stIdle;
            idx      <= FIRST_IDX;
            busy     <= 1'b0;
            done     <= 1'b0;
            halt_req <= 1'b0;
            outValid <= 1'b0;
            outAddr  <= '0;
            outData  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                stIdle: begin
                    if (start) begin
                        halt_req <= 1'b1;
                        busy     <= 1'b1;
                        idx      <= FIRST_IDX;
                        state    <= stHaltWait;
                    end
                end

                stHaltWait: begin
                    if (halt_ack) state <= stRead;
                end

                stRead: begin
                    // Losing the halt means rf_data may be changing: re-read later.
                    if (!halt_ack) begin
                        state <= stHaltWait;
                    end else if (SKIP_ZERO && rf_data == '0) begin
                        if (isLast) begin
                            halt_req <= 1'b0;
                            done     <= 1'b1;
                            state    <= stDone;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        outAddr  <= idx;
                        outData  <= rf_data;
                        outValid <= 1'b1;
                        state    <= stSend;
                    end
                end

                stSend: begin
                    if (beatOut.out_ready) begin
                        outValid <= 1'b0;
                        if (isLast) begin
                            halt_req <= 1'b0;
                            done     <= 1'b1;
                            state    <= stDone;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= stRead;
                        end
                    end
                end

                stDone: begin
                    busy  <= 1'b0;
                    state <= stIdle;
                end

                default: begin
                    busy     <= 1'b0;
                    halt_req <= 1'b0;
                    outValid <= 1'b0;
                    state    <= stIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_dump.sv
// Directed bench for rf_dump: one instance walking all registers, one with
// zero-valued registers suppressed.
module tb_rf_dump;
    import rf_dbg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        startA, busyA, doneA, haltReqA, haltAckA;
    logic [4:0]  rfAddrA;
    logic [31:0] rfDataA;
    logic [31:0] regsA [32];
    assign rfDataA = regsA[rfAddrA];
    rf_dump_if #(.ADDR_W(5), .DATA_W(32)) busA ();

    logic        startZ, busyZ, doneZ, haltReqZ, haltAckZ;
    logic [4:0]  rfAddrZ;
    logic [31:0] rfDataZ;
    logic [31:0] regsZ [32];
    assign rfDataZ = regsZ[rfAddrZ];
    rf_dump_if #(.ADDR_W(5), .DATA_W(32)) busZ ();

    rf_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(1), .SKIP_ZERO(1'b0)) dutA (
        .clk(clk), .rst(rst), .start(startA), .busy(busyA), .done(doneA),
        .halt_req(haltReqA), .halt_ack(haltAckA), .rf_addr(rfAddrA), .rf_data(rfDataA),
        .beatOut(busA)
    );

    rf_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(1), .SKIP_ZERO(1'b1)) dutZ (
        .clk(clk), .rst(rst), .start(startZ), .busy(busyZ), .done(doneZ),
        .halt_req(haltReqZ), .halt_ack(haltAckZ), .rf_addr(rfAddrZ), .rf_data(rfDataZ),
        .beatOut(busZ)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    logic [36:0] beatsA [$];
    int          beatCycA [$];
    int          firstValidA, stableErrA, haltErrA, haltAtDoneA, haltBeforeDoneA;
    bit          finishedA;

    logic [36:0] beatsZ [$];
    int          doneCycZ;
    bit          finishedZ;

    function automatic logic [36:0] expA(input int i);
        return {5'(i), 32'h1000_0000 + 32'(i)};
    endfunction

    // Runs one dump on dutA starting at the current negedge; every input is
    // driven and every output sampled on negedges.
    task automatic dumpA(input int readyPct, input int holdOff, input int dropAddr,
                         input int restartAddr, input int budget);
        logic        pValid, pReady, pHalt, ackWasLow;
        logic [4:0]  pAddr;
        logic [31:0] pData;
        int          ackLow;
        bit          dropArmed, restartDone;
        beatsA.delete();
        beatCycA.delete();
        firstValidA = -1; stableErrA = 0; haltErrA = 0; finishedA = 1'b0;
        haltAtDoneA = -1; haltBeforeDoneA = -1;
        dropArmed = 1'b0; restartDone = 1'b0;
        ackLow = holdOff;
        startA = 1'b1;
        if (ackLow > 0) begin haltAckA = 1'b0; ackLow--; end else haltAckA = 1'b1;
        busA.out_ready = ($urandom_range(99) < readyPct);
        pValid = 1'b0; pReady = 1'b0; pHalt = 1'b0; pAddr = '0; pData = '0;
        for (int c = 1; c <= budget && !finishedA; c++) begin
            @(negedge clk);
            startA = 1'b0;
            ackWasLow = !haltAckA;
            if (ackWasLow && (busyA !== 1'b1 || haltReqA !== 1'b1 || busA.out_valid !== 1'b0))
                haltErrA++;
            if (ackWasLow && dropAddr >= 0 && rfAddrA !== 5'(dropAddr))
                haltErrA++;
            if (pValid && !pReady && (busA.out_valid !== 1'b1 || busA.out_addr !== pAddr ||
                                      busA.out_data !== pData))
                stableErrA++;
            if (busA.out_valid === 1'b1 && firstValidA < 0) firstValidA = c;
            if (doneA === 1'b1) begin
                finishedA       = 1'b1;
                haltAtDoneA     = int'(haltReqA);
                haltBeforeDoneA = int'(pHalt);
            end
            if (dropArmed) begin dropArmed = 1'b0; ackLow = 3; end
            if (ackLow > 0) begin haltAckA = 1'b0; ackLow--; end else haltAckA = 1'b1;
            if (!restartDone && restartAddr >= 0 && busA.out_valid === 1'b1 &&
                busA.out_addr === 5'(restartAddr)) begin
                startA = 1'b1;
                restartDone = 1'b1;
            end
            busA.out_ready = ($urandom_range(99) < readyPct);
            if (busA.out_valid === 1'b1 && busA.out_ready) begin
                beatsA.push_back({busA.out_addr, busA.out_data});
                beatCycA.push_back(c);
                if (dropAddr >= 0 && int'(busA.out_addr) == dropAddr - 1) dropArmed = 1'b1;
            end
            pValid = busA.out_valid; pReady = busA.out_ready; pHalt = haltReqA;
            pAddr = busA.out_addr; pData = busA.out_data;
        end
    endtask

    task automatic dumpZ(input int budget);
        beatsZ.delete();
        doneCycZ = -1; finishedZ = 1'b0;
        startZ = 1'b1; haltAckZ = 1'b1; busZ.out_ready = 1'b1;
        for (int c = 1; c <= budget && !finishedZ; c++) begin
            @(negedge clk);
            startZ = 1'b0;
            if (doneZ === 1'b1) begin finishedZ = 1'b1; doneCycZ = c; end
            if (busZ.out_valid === 1'b1) beatsZ.push_back({busZ.out_addr, busZ.out_data});
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; startA = 1'b0; startZ = 1'b0; haltAckA = 1'b1; haltAckZ = 1'b1;
        busA.out_ready = 1'b0; busZ.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        nCompared++;
        if ({busyA, doneA, haltReqA, busA.out_valid} !== 4'b0000) begin
            nMismatched++;
            $display("FAIL reset_flags_a: got busy/done/halt/valid=%b want 0000",
                     {busyA, doneA, haltReqA, busA.out_valid});
        end
        nCompared++;
        if ({busA.out_addr, busA.out_data} !== 37'd0) begin
            nMismatched++;
            $display("FAIL reset_beat_a: got addr=%0d data=%h want 0/0", busA.out_addr, busA.out_data);
        end
        nCompared++;
        if (rfAddrA !== 5'd1) begin
            nMismatched++;
            $display("FAIL reset_rf_addr_a: got %0d want 1", rfAddrA);
        end
        nCompared++;
        if ({busyZ, doneZ, haltReqZ, busZ.out_valid, rfAddrZ} !== {4'b0000, 5'd1}) begin
            nMismatched++;
            $display("FAIL reset_z: got flags=%b rf_addr=%0d want 0000/1",
                     {busyZ, doneZ, haltReqZ, busZ.out_valid}, rfAddrZ);
        end
        rst = 1'b0;
        @(negedge clk);
        nCompared++;
        if ({busyA, haltReqA} !== 2'b00) begin
            nMismatched++;
            $display("FAIL idle_after_reset: got busy/halt=%b want 00", {busyA, haltReqA});
        end
    endtask

    task automatic test_full_dump;
        int errs, gapErrs;
        dumpA(100, 0, -1, -1, 200);
        errs = 0; gapErrs = 0;
        for (int i = 0; i < beatsA.size(); i++) if (beatsA[i] !== expA(i + 1)) errs++;
        for (int i = 1; i < beatCycA.size(); i++) if (beatCycA[i] - beatCycA[i-1] != 2) gapErrs++;
        nCompared++;
        if (!finishedA || beatsA.size() != 31 || errs != 0) begin
            nMismatched++;
            $display("FAIL full_sequence: got done=%0d beats=%0d bad=%0d want 1/31/0",
                     finishedA, beatsA.size(), errs);
        end
        nCompared++;
        if (firstValidA != 3) begin
            nMismatched++;
            $display("FAIL first_valid_latency: got %0d cycles want 3", firstValidA);
        end
        nCompared++;
        if (gapErrs != 0) begin
            nMismatched++;
            $display("FAIL beat_spacing: got %0d gaps not equal to 2, want 0", gapErrs);
        end
        nCompared++;
        if (haltBeforeDoneA != 1 || haltAtDoneA != 0) begin
            nMismatched++;
            $display("FAIL halt_falls_with_done: got before=%0d at=%0d want 1/0",
                     haltBeforeDoneA, haltAtDoneA);
        end
        @(negedge clk);
        nCompared++;
        if ({doneA, busyA} !== 2'b00) begin
            nMismatched++;
            $display("FAIL done_single_pulse: got done/busy=%b want 00", {doneA, busyA});
        end
    endtask

    task automatic test_random_ready;
        int errs;
        @(negedge clk);
        dumpA(30, 0, -1, -1, 2000);
        errs = 0;
        for (int i = 0; i < beatsA.size(); i++) if (beatsA[i] !== expA(i + 1)) errs++;
        nCompared++;
        if (!finishedA || beatsA.size() != 31 || errs != 0) begin
            nMismatched++;
            $display("FAIL random_ready_sequence: got done=%0d beats=%0d bad=%0d want 1/31/0",
                     finishedA, beatsA.size(), errs);
        end
        nCompared++;
        if (stableErrA != 0) begin
            nMismatched++;
            $display("FAIL beat_hold_stable: got %0d unstable cycles want 0", stableErrA);
        end
    endtask

    task automatic test_halt_wait;
        int errs;
        @(negedge clk);
        busA.out_ready = 1'b1;
        dumpA(100, 10, -1, -1, 300);
        errs = 0;
        for (int i = 0; i < beatsA.size(); i++) if (beatsA[i] !== expA(i + 1)) errs++;
        nCompared++;
        if (haltErrA != 0) begin
            nMismatched++;
            $display("FAIL halt_wait_hold: got %0d bad cycles while ack low want 0", haltErrA);
        end
        nCompared++;
        if (firstValidA != 12 || beatsA.size() != 31 || errs != 0) begin
            nMismatched++;
            $display("FAIL halt_wait_resume: got first=%0d beats=%0d bad=%0d want 12/31/0",
                     firstValidA, beatsA.size(), errs);
        end
    endtask

    task automatic test_halt_drop;
        int errs;
        @(negedge clk);
        dumpA(100, 0, 7, -1, 300);
        errs = 0;
        for (int i = 0; i < beatsA.size(); i++) if (beatsA[i] !== expA(i + 1)) errs++;
        nCompared++;
        if (haltErrA != 0) begin
            nMismatched++;
            $display("FAIL halt_drop_hold: got %0d bad cycles while ack low want 0", haltErrA);
        end
        nCompared++;
        if (beatsA.size() != 31 || errs != 0) begin
            nMismatched++;
            $display("FAIL halt_drop_sequence: got beats=%0d bad=%0d want 31/0", beatsA.size(), errs);
        end
        nCompared++;
        if (beatCycA.size() < 7 || beatCycA[6] - beatCycA[5] != 6) begin
            nMismatched++;
            $display("FAIL halt_drop_reread: got gap before addr 7 = %0d want 6",
                     (beatCycA.size() < 7) ? -1 : beatCycA[6] - beatCycA[5]);
        end
    endtask

    task automatic test_reset_mid;
        bit found;
        int doneSeen;
        @(negedge clk);
        startA = 1'b1; haltAckA = 1'b1; busA.out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            startA = 1'b0;
            if (busA.out_valid === 1'b1 && busA.out_addr === 5'd12) found = 1'b1;
        end
        nCompared++;
        if (!found) begin
            nMismatched++;
            $display("FAIL reset_mid_reach_send12: got timeout want SEND at addr 12");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nCompared++;
        if ({busyA, busA.out_valid, haltReqA, doneA, rfAddrA} !== {4'b0000, 5'd1}) begin
            nMismatched++;
            $display("FAIL reset_mid_abort: got busy/valid/halt/done=%b rf_addr=%0d want 0000/1",
                     {busyA, busA.out_valid, haltReqA, doneA}, rfAddrA);
        end
        doneSeen = 0;
        repeat (5) begin
            @(negedge clk);
            if (doneA === 1'b1) doneSeen++;
        end
        nCompared++;
        if (doneSeen != 0) begin
            nMismatched++;
            $display("FAIL reset_mid_no_done: got %0d done pulses want 0", doneSeen);
        end
        dumpA(100, 0, -1, -1, 200);
        nCompared++;
        if (beatsA.size() != 31 || beatsA[0] !== expA(1)) begin
            nMismatched++;
            $display("FAIL reset_mid_redump: got beats=%0d first=%h want 31/%h",
                     beatsA.size(), (beatsA.size() > 0) ? beatsA[0] : 37'd0, expA(1));
        end
    endtask

    task automatic test_start_boundaries;
        int errs;
        @(negedge clk);
        dumpA(100, 0, -1, 4, 200);
        errs = 0;
        for (int i = 0; i < beatsA.size(); i++) if (beatsA[i] !== expA(i + 1)) errs++;
        nCompared++;
        if (!finishedA || beatsA.size() != 31 || errs != 0) begin
            nMismatched++;
            $display("FAIL start_while_busy: got done=%0d beats=%0d bad=%0d want 1/31/0",
                     finishedA, beatsA.size(), errs);
        end
        startA = 1'b1;
        @(negedge clk);
        nCompared++;
        if ({busyA, doneA} !== 2'b00) begin
            nMismatched++;
            $display("FAIL start_in_done: got busy/done=%b want 00", {busyA, doneA});
        end
        dumpA(100, 0, -1, -1, 200);
        errs = 0;
        for (int i = 0; i < beatsA.size(); i++) if (beatsA[i] !== expA(i + 1)) errs++;
        nCompared++;
        if (firstValidA != 3 || beatsA.size() != 31 || errs != 0) begin
            nMismatched++;
            $display("FAIL start_after_done: got first=%0d beats=%0d bad=%0d want 3/31/0",
                     firstValidA, beatsA.size(), errs);
        end
    endtask

    task automatic test_skip_zero;
        for (int i = 0; i < 32; i++) regsZ[i] = 32'd0;
        regsZ[5]  = 32'hDEAD_BEEF;
        regsZ[31] = 32'h0000_0001;
        @(negedge clk);
        dumpZ(200);
        nCompared++;
        if (beatsZ.size() != 2) begin
            nMismatched++;
            $display("FAIL skip_zero_count: got %0d beats want 2", beatsZ.size());
        end else begin
            nCompared++;
            if (beatsZ[0] !== {5'd5, 32'hDEAD_BEEF} || beatsZ[1] !== {5'd31, 32'h1}) begin
                nMismatched++;
                $display("FAIL skip_zero_beats: got %h %h want %h %h",
                         beatsZ[0], beatsZ[1], {5'd5, 32'hDEAD_BEEF}, {5'd31, 32'h1});
            end
        end
        nCompared++;
        if (doneCycZ != 35) begin
            nMismatched++;
            $display("FAIL skip_zero_done: got done at cycle %0d want 35", doneCycZ);
        end
        regsZ[5] = 32'd0; regsZ[31] = 32'd0;
        @(negedge clk);
        dumpZ(200);
        nCompared++;
        if (beatsZ.size() != 0 || doneCycZ != 33) begin
            nMismatched++;
            $display("FAIL all_zero_dump: got beats=%0d done cycle=%0d want 0/33",
                     beatsZ.size(), doneCycZ);
        end
    endtask

    initial begin
        rst = 1'b1;
        startA = 1'b0; startZ = 1'b0; haltAckA = 1'b1; haltAckZ = 1'b1;
        busA.out_ready = 1'b0; busZ.out_ready = 1'b0;
        regsA[0] = 32'd0;
        for (int i = 1; i < 32; i++) regsA[i] = 32'h1000_0000 + 32'(i);
        for (int i = 0; i < 32; i++) regsZ[i] = 32'd0;

        test_reset();
        test_full_dump();
        test_random_ready();
        test_halt_wait();
        test_halt_drop();
        test_reset_mid();
        test_start_boundaries();
        test_skip_zero();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
